// File: rtl/rv_fetch_pkg.sv
// Shared fetch-stage types and constants: the queue entry layout and the NOP word.
package rv_fetch_pkg;
  localparam int          CORE_WIDTH  = 2;
  localparam int          INSTR_BYTES = 4;
  localparam int          BLK_W       = CORE_WIDTH * 32;
  localparam logic [31:0] NOP_INSTR   = 32'h00000013;

  // One fetched block tagged with the PC of slot 0.
  typedef struct packed {
    logic [31:0]      pc;
    logic [BLK_W-1:0] blk;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction memory address/data, redirect input and decode handshake.
// master = fetch_unit side, slave = memory/decode/branch environment side.
interface fetch_unit_if #(
  parameter int CORE_WIDTH = rv_fetch_pkg::CORE_WIDTH
) ();
  logic [31:0]              pc_addr;
  logic [CORE_WIDTH*32-1:0] instruction_blk;
  logic                     redirect_valid;
  logic [31:0]              redirect_pc;
  logic                     out_valid;
  logic                     out_ready;
  logic [CORE_WIDTH*32-1:0] out_blk;
  logic [31:0]              out_pc;

  modport master (
    output pc_addr, out_valid, out_blk, out_pc,
    input  instruction_blk, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  pc_addr, out_valid, out_blk, out_pc,
    output instruction_blk, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Circular FIFO of fetch entries. Occupancy is an explicit count so full and
// empty stay distinct; flush clears pointers and count in one cycle.
module fetch_queue
  import rv_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         enq,
  input  logic         deq,
  input  fetch_entry_t enq_data,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Entry storage: written on enqueue, no reset needed since head is gated by count.
  always_ff @(posedge clk) begin
    if (enq && !flush && !rst) mem_q[wr_ptr] <= enq_data;
  end

  // Pointer and occupancy bookkeeping; flush wins over enq/deq.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_ONE;
      if (deq) rd_ptr <= rd_ptr + PTR_ONE;
      case ({enq, deq})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Oldest entry, forced to zero when the queue is empty.
  always_comb begin
    head = '0;
    if (count != '0) head = mem_q[rd_ptr];
  end
endmodule

// File: rtl/fetch_unit.sv
// Front-end fetch stage: owns the PC, captures instruction blocks from a
// combinational instruction memory into a fetch queue, and hands them to
// decode over valid/ready. Redirects flush the queue and reload the PC.
// Optional build macro FETCH_PERF_EN adds saturating enqueue/stall counters.
module fetch_unit
  import rv_fetch_pkg::*;
#(
  parameter int          CORE_WIDTH    = rv_fetch_pkg::CORE_WIDTH,
  parameter int          FETCH_Q_DEPTH = 4,
  parameter logic [31:0] RESET_PC      = 32'h00000000
) (
  input  logic              clk,
  input  logic              rst,
  fetch_unit_if.master      bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);
  localparam int          CW      = $clog2(FETCH_Q_DEPTH) + 1;
  localparam logic [CW-1:0] Q_FULL = CW'(FETCH_Q_DEPTH);
  localparam logic [31:0] PC_STEP = 32'(CORE_WIDTH * INSTR_BYTES);

  logic [31:0]   pc;
  logic          enq;
  logic          deq;
  logic [CW-1:0] count;
  fetch_entry_t  enq_data;
  fetch_entry_t  head;
  logic [1:0]    unused_rpc_lo;

  assign unused_rpc_lo = bus.redirect_pc[1:0];

  // Handshake arbitration: redirect suppresses both accept and fetch; a full
  // queue still fetches when decode drains an entry the same cycle.
  assign bus.out_valid = (count != '0) && !bus.redirect_valid;
  assign deq           = bus.out_valid && bus.out_ready;
  assign enq           = !bus.redirect_valid && ((count < Q_FULL) || deq);

  assign bus.pc_addr = pc;
  assign enq_data    = {pc, bus.instruction_blk};
  assign bus.out_blk = head.blk;
  assign bus.out_pc  = head.pc;

  // PC register: reset, then redirect (word-aligned), then sequential advance.
  always_ff @(posedge clk) begin
    if (rst)                     pc <= {RESET_PC[31:2], 2'b00};
    else if (bus.redirect_valid) pc <= {bus.redirect_pc[31:2], 2'b00};
    else if (enq)                pc <= pc + PC_STEP;
  end

  fetch_queue #(
    .DEPTH (FETCH_Q_DEPTH)
  ) u_queue (
    .clk      (clk),
    .rst      (rst),
    .flush    (bus.redirect_valid),
    .enq      (enq),
    .deq      (deq),
    .enq_data (enq_data),
    .head     (head),
    .count    (count)
  );

`ifdef FETCH_PERF_EN
  // Saturating perf counters; only reset clears them, redirects do not.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (enq && (perf_fetch_cnt != '1))
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (!bus.redirect_valid && !enq && (perf_stall_cnt != '1))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif
endmodule
